jtopl_timer_bank: RTL

//  Parametrised bank of N OPL-style interval timers sharing one prescaled time base (cenop & zero).

---
 rtl/jtopl_tmr_pkg.sv | 21 ++
 rtl/jtopl_timer_ch.sv | 86 ++++++++
 rtl/jtopl_timer_bank.sv | 73 +++++++
 3 files changed

// File: rtl/jtopl_tmr_pkg.sv
//------------------------------------------------------------------------------
// Module   : jtopl_tmr_pkg
// Purpose  : Shared limits, default prescaler widths and helpers for the timer bank.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jtopl_tmr_pkg;

  localparam int TMR_NMAX = 8;

  // Channel 0 in the low nibble: ch0 prescaler 2 bits, ch1 prescaler 4 bits.
  localparam logic [7:0] PW_DEFAULT = {4'd4, 4'd2};

  function automatic logic [15:0] ones(input int w);
    return 16'((32'd1 << w) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtopl_timer_ch.sv
//------------------------------------------------------------------------------
// Module   : jtopl_timer_ch
// Purpose  : One interval timer: free-running prescaler, reloading up-counter,
//            start edge detector and sticky maskable flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtopl_timer_ch
  import jtopl_tmr_pkg::*;
#(
  parameter int CW = 8,
  parameter int PW = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [CW-1:0] value,
  input  logic          start,
  input  logic          mask,
  input  logic          clr_flag,
  input  logic          irq_rst,
  output logic          flag,
  output logic          ovf,
  output logic          ovf_nxt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(ones(CW));

  logic          carry;
  logic          start_d;
  logic          rise;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // The prescaler never looks at start so the tempo is kept across stops.
  if (PW == 0) begin : g_nopre
    assign carry = tick;
  end else begin : g_pre
    logic [PW-1:0] pre;

    always_ff @(posedge clk) begin
      if (rst)       pre <= '0;
      else if (tick) pre <= pre + 1'b1;
    end

    assign carry = tick & (&pre);
  end

  assign rise = start & ~start_d;

  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = 1'b0;
    if (rise) begin
      cnt_nxt = value;
    end else if (start && carry) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt = value;
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_d <= 1'b0;
      cnt     <= value;
      ovf     <= 1'b0;
      flag    <= 1'b0;
    end else begin
      start_d <= start;
      cnt     <= cnt_nxt;
      ovf     <= ovf_nxt;
      // Clears beat a coincident overflow; mask only blocks setting.
      if (irq_rst)             flag <= 1'b0;
      else if (clr_flag)       flag <= 1'b0;
      else if (ovf && !mask)   flag <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtopl_timer_bank.sv
//------------------------------------------------------------------------------
// Module   : jtopl_timer_bank
// Purpose  : Bank of N OPL interval timers on a shared cenop&zero time base.
//            Optional macro JTOPL_TMR_CSM_EN enables the CSM key-on pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtopl_timer_bank
  import jtopl_tmr_pkg::*;
#(
  parameter int               N  = 2,
  parameter int               CW = 8,
  parameter logic [N*4-1:0]   PW = PW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cenop,
  input  logic            zero,
  input  logic [N*CW-1:0] value,
  input  logic [N-1:0]    start,
  input  logic [N-1:0]    mask,
  input  logic [N-1:0]    clr_flag,
  input  logic            irq_rst,
  input  logic            csm_en,
  output logic [N-1:0]    flags,
  output logic [N-1:0]    ovf,
  output logic            irq_n,
  output logic            csm_kon
);

  logic         tick;
  logic [N-1:0] ovf_nxt;
  logic         unused_csm;

  assign tick = cenop & zero;

  for (genvar i = 0; i < N; i++) begin : g_ch
    jtopl_timer_ch #(
      .CW (CW),
      .PW (int'(PW[i*4 +: 4]))
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .value    (value[i*CW +: CW]),
      .start    (start[i]),
      .mask     (mask[i]),
      .clr_flag (clr_flag[i]),
      .irq_rst  (irq_rst),
      .flag     (flags[i]),
      .ovf      (ovf[i]),
      .ovf_nxt  (ovf_nxt[i])
    );
  end

  assign irq_n = ~|flags;

`ifdef JTOPL_TMR_CSM_EN
  // Registered from the same next-state term as ovf[0] so both rise together.
  always_ff @(posedge clk) begin
    if (rst) csm_kon <= 1'b0;
    else     csm_kon <= ovf_nxt[0] & csm_en;
  end
  assign unused_csm = &{1'b0, ovf_nxt};
`else
  assign csm_kon    = 1'b0;
  assign unused_csm = &{1'b0, csm_en, ovf_nxt};
`endif

endmodule

`default_nettype wire
